axi_interconnect_crossbar_arbit_ctrl: RTL

- Sequential grant controller for one crossbar slave port; sits directly downstream of the round-robin polling arbiter.
- Drives the arbiter's `user_req`/`last_user` inputs and captures its combinational `current_user` result into a registered grant.
- Holds the grant through the address handshake and the data/response phase of one transaction, then releases and advances round-robin priority.
- The grant outputs select the crossbar address/data muxes.

---
 rtl/axi_interconnect_crossbar_arbit_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/axi_interconnect_crossbar_arbit_ctrl.sv
// Grant controller for one crossbar slave port: drives the round-robin polling arbiter,
// registers its winner and holds the grant through address and data/response phases.
module axi_interconnect_crossbar_arbit_ctrl #(
  parameter int unsigned NUM     = 2,
  parameter int unsigned WIDTH   = (NUM > 2) ? $clog2(NUM) : 1,
  parameter int unsigned TIMEOUT = 0,
  parameter int unsigned TO_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NUM-1:0]   m_req,
  output logic [NUM-1:0]   arb_user_req,
  output logic [WIDTH-1:0] arb_last_user,
  input  logic [WIDTH-1:0] arb_current_user,
  input  logic             s_addr_hs,
  input  logic             s_done,
  output logic             grant_valid,
  output logic [WIDTH-1:0] grant_id,
  output logic [NUM-1:0]   grant_oh,
  output logic             busy,
  output logic             timeout
);

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StData
  } state_e;

  // Counter value on the last permitted DATA cycle; unused when the watchdog is disabled.
  localparam logic [TO_W-1:0] ToLast = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);
  localparam logic [WIDTH-1:0] LastReset = WIDTH'(NUM - 1);

  state_e           state_q, state_d;
  logic             grant_valid_q, grant_valid_d;
  logic [WIDTH-1:0] grant_id_q, grant_id_d;
  logic [WIDTH-1:0] last_user_q, last_user_d;
  logic             done_seen_q, done_seen_d;
  logic [TO_W-1:0]  cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic             to_expire;

  assign to_expire = (TIMEOUT != 0) && (cnt_q == ToLast);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      last_user_q   <= LastReset;
      done_seen_q   <= 1'b0;
      cnt_q         <= '0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_valid_q <= grant_valid_d;
      grant_id_q    <= grant_id_d;
      last_user_q   <= last_user_d;
      done_seen_q   <= done_seen_d;
      cnt_q         <= cnt_d;
      timeout_q     <= timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_valid_d = grant_valid_q;
    grant_id_d    = grant_id_q;
    last_user_d   = last_user_q;
    done_seen_d   = done_seen_q;
    cnt_d         = cnt_q;
    timeout_d     = 1'b0;

    case (state_q)
      StIdle: begin
        if (|m_req) begin
          grant_id_d    = arb_current_user;
          grant_valid_d = 1'b1;
          state_d       = StAddr;
        end
      end

      StAddr: begin
        if (s_addr_hs) begin
          last_user_d = grant_id_q;
          // Write data may have completed before the address handshake.
          if (done_seen_q || s_done) begin
            state_d       = StIdle;
            grant_valid_d = 1'b0;
            done_seen_d   = 1'b0;
          end else begin
            state_d = StData;
            cnt_d   = '0;
          end
        end else if (s_done) begin
          done_seen_d = 1'b1;
        end
      end

      StData: begin
        cnt_d = cnt_q + 1'b1;
        if (s_done) begin
          state_d       = StIdle;
          grant_valid_d = 1'b0;
        end else if (to_expire) begin
          state_d       = StIdle;
          grant_valid_d = 1'b0;
          timeout_d     = 1'b1;
        end
      end

      default: begin
        state_d       = StIdle;
        grant_valid_d = 1'b0;
        done_seen_d   = 1'b0;
      end
    endcase
  end

  assign arb_user_req  = (state_q == StIdle) ? m_req : '0;
  assign arb_last_user = last_user_q;
  assign grant_valid   = grant_valid_q;
  assign grant_id      = grant_id_q;
  assign grant_oh      = grant_valid_q ? (NUM'(1) << grant_id_q) : '0;
  assign busy          = (state_q != StIdle);
  assign timeout       = timeout_q;

endmodule
